// File: rtl/mem_stage_if.sv
// Pipeline-side bus of the memory stage: execute-stage inputs, write-back
// outputs and the debug memory port.
interface mem_stage_if #(
  parameter int NB_DATA  = 32,
  parameter int NB_REG   = 5,
  parameter int NB_WADDR = 5
) ();
  logic                i_step;
  logic                i_reg_write;
  logic                i_mem_to_reg;
  logic                i_mem_read;
  logic                i_mem_write;
  logic [1:0]          i_width;
  logic                i_unsigned;
  logic [NB_DATA-1:0]  i_alu_result;
  logic [NB_DATA-1:0]  i_store_data;
  logic [NB_REG-1:0]   i_selected_reg;
  logic [NB_WADDR-1:0] i_debug_addr;

  logic                o_reg_write;
  logic                o_mem_to_reg;
  logic [NB_DATA-1:0]  o_mem_data;
  logic [NB_DATA-1:0]  o_alu_result;
  logic [NB_REG-1:0]   o_selected_reg;
  logic                o_misaligned;
  logic [NB_DATA-1:0]  o_debug_data;

  modport master (
    output i_step, i_reg_write, i_mem_to_reg, i_mem_read, i_mem_write,
           i_width, i_unsigned, i_alu_result, i_store_data, i_selected_reg,
           i_debug_addr,
    input  o_reg_write, o_mem_to_reg, o_mem_data, o_alu_result,
           o_selected_reg, o_misaligned, o_debug_data
  );

  modport slave (
    input  i_step, i_reg_write, i_mem_to_reg, i_mem_read, i_mem_write,
           i_width, i_unsigned, i_alu_result, i_store_data, i_selected_reg,
           i_debug_addr,
    output o_reg_write, o_mem_to_reg, o_mem_data, o_alu_result,
           o_selected_reg, o_misaligned, o_debug_data
  );
endinterface

// File: rtl/mem_stage.sv
// Pipeline memory stage: little-endian byte/half/word data memory with
// lane-masked stores, sign/zero-extended loads, misalignment detection and
// registered hand-off to write-back. Memory and outputs clear on async reset.
module mem_stage #(
  parameter int NB_DATA  = 32,
  parameter int NB_REG   = 5,
  parameter int NB_WADDR = 5
) (
  input logic        i_clk,
  input logic        i_rst_n,
  mem_stage_if.slave bus
);
  localparam int unsigned DEPTH    = 2 ** NB_WADDR;
  localparam int unsigned NB_LANES = NB_DATA / 8;

  typedef enum logic [1:0] {
    W_BYTE = 2'b00,
    W_HALF = 2'b01,
    W_WORD = 2'b10,
    W_RSVD = 2'b11
  } width_e;

  logic [NB_DATA-1:0]  mem [DEPTH];

  logic [NB_WADDR-1:0] word_idx;
  logic [1:0]          offset;
  logic                misaligned;
  logic                do_store;
  logic [NB_LANES-1:0] lane_en;
  logic [NB_DATA-1:0]  rd_word;
  logic [NB_DATA-1:0]  rd_shift;
  logic [NB_DATA-1:0]  load_val;
  logic [NB_DATA-1:0]  wr_pattern;
  logic [NB_DATA-1:0]  merged;

  logic                reg_write_q;
  logic                mem_to_reg_q;
  logic [NB_DATA-1:0]  mem_data_q;
  logic [NB_DATA-1:0]  alu_result_q;
  logic [NB_REG-1:0]   selected_reg_q;
  logic                misaligned_q;

  // Upper address bits are dropped so accesses wrap modulo the depth.
  assign word_idx = bus.i_alu_result[NB_WADDR+1:2];
  assign offset   = bus.i_alu_result[1:0];
  assign rd_word  = mem[word_idx];
  assign rd_shift = rd_word >> {offset, 3'b000};
  assign do_store = bus.i_step & bus.i_mem_write & ~misaligned;

  // Decode access size: alignment, lane mask, store pattern and load extension.
  always_comb begin
    misaligned = 1'b0;
    lane_en    = '0;
    wr_pattern = bus.i_store_data;
    load_val   = rd_word;
    case (width_e'(bus.i_width))
      W_BYTE: begin
        lane_en    = NB_LANES'(1) << offset;
        wr_pattern = {NB_LANES{bus.i_store_data[7:0]}};
        load_val   = {{(NB_DATA-8){~bus.i_unsigned & rd_shift[7]}}, rd_shift[7:0]};
      end
      W_HALF: begin
        misaligned = offset[0];
        lane_en    = NB_LANES'(3) << offset;
        wr_pattern = {(NB_LANES/2){bus.i_store_data[15:0]}};
        load_val   = {{(NB_DATA-16){~bus.i_unsigned & rd_shift[15]}}, rd_shift[15:0]};
      end
      W_WORD: begin
        misaligned = (offset != 2'b00);
        lane_en    = '1;
      end
      default: begin
        misaligned = 1'b1;
        load_val   = '0;
      end
    endcase
  end

  // Merge replicated store pattern into the current word on enabled lanes only.
  always_comb begin
    merged = rd_word;
    for (int unsigned k = 0; k < NB_LANES; k++) begin
      if (lane_en[k]) merged[8*k +: 8] = wr_pattern[8*k +: 8];
    end
  end

  // Data memory: cleared by reset, written on stepped aligned stores.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (do_store) begin
      mem[word_idx] <= merged;
    end
  end

  // Write-back hand-off registers; load data samples the pre-store word.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      reg_write_q    <= 1'b0;
      mem_to_reg_q   <= 1'b0;
      mem_data_q     <= '0;
      alu_result_q   <= '0;
      selected_reg_q <= '0;
      misaligned_q   <= 1'b0;
    end else if (bus.i_step) begin
      reg_write_q    <= bus.i_reg_write;
      mem_to_reg_q   <= bus.i_mem_to_reg;
      mem_data_q     <= (bus.i_mem_read && !misaligned) ? load_val : '0;
      alu_result_q   <= bus.i_alu_result;
      selected_reg_q <= bus.i_selected_reg;
      misaligned_q   <= misaligned & (bus.i_mem_read | bus.i_mem_write);
    end
  end

  assign bus.o_reg_write    = reg_write_q;
  assign bus.o_mem_to_reg   = mem_to_reg_q;
  assign bus.o_mem_data     = mem_data_q;
  assign bus.o_alu_result   = alu_result_q;
  assign bus.o_selected_reg = selected_reg_q;
  assign bus.o_misaligned   = misaligned_q;
  assign bus.o_debug_data   = mem[bus.i_debug_addr];
endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: loads/stores of all sizes, misalignment,
// step freeze, read-before-write, asynchronous reset and address wrap.
module tb_mem_stage;
  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_pass;

  mem_stage_if #(.NB_DATA(32), .NB_REG(5), .NB_WADDR(5)) bus ();

  mem_stage #(.NB_DATA(32), .NB_REG(5), .NB_WADDR(5)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
  endtask

  task automatic drive(input logic step, input logic rw, input logic m2r,
                       input logic rd, input logic wr, input logic [1:0] w,
                       input logic uns, input logic [31:0] alu,
                       input logic [31:0] sd, input logic [4:0] sel,
                       input logic [4:0] dbg);
    bus.i_step         = step;
    bus.i_reg_write    = rw;
    bus.i_mem_to_reg   = m2r;
    bus.i_mem_read     = rd;
    bus.i_mem_write    = wr;
    bus.i_width        = w;
    bus.i_unsigned     = uns;
    bus.i_alu_result   = alu;
    bus.i_store_data   = sd;
    bus.i_selected_reg = sel;
    bus.i_debug_addr   = dbg;
  endtask

  // Apply inputs at the falling edge, clock once, sample 1 after the rising edge.
  task automatic op(input logic step, input logic rw, input logic m2r,
                    input logic rd, input logic wr, input logic [1:0] w,
                    input logic uns, input logic [31:0] alu,
                    input logic [31:0] sd, input logic [4:0] sel,
                    input logic [4:0] dbg);
    @(negedge clk);
    drive(step, rw, m2r, rd, wr, w, uns, alu, sd, sel, dbg);
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rst_n    = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0, 5'd0, 5'd0);
    @(posedge clk);
    #1;
    chk("rst_mem_data",   bus.o_mem_data, 32'h0);
    chk("rst_alu_result", bus.o_alu_result, 32'h0);
    chk("rst_misaligned", {31'b0, bus.o_misaligned}, 32'h0);
    chk("rst_debug0",     bus.o_debug_data, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // SW 0xDEADBEEF @ 0x8
    op(1, 1, 0, 0, 1, 2'b10, 0, 32'h8, 32'hDEADBEEF, 5'd5, 5'd2);
    chk("sw_debug2",    bus.o_debug_data, 32'hDEADBEEF);
    chk("sw_mem_data",  bus.o_mem_data, 32'h0);
    chk("sw_alu",       bus.o_alu_result, 32'h8);
    chk("sw_reg_write", {31'b0, bus.o_reg_write}, 32'h1);
    chk("sw_m2r",       {31'b0, bus.o_mem_to_reg}, 32'h0);
    chk("sw_sel",       {27'b0, bus.o_selected_reg}, 32'd5);
    chk("sw_mis",       {31'b0, bus.o_misaligned}, 32'h0);

    // Loads of each size / extension
    op(1, 1, 1, 1, 0, 2'b10, 0, 32'h8, 32'h0, 5'd9, 5'd2);
    chk("lw_8",   bus.o_mem_data, 32'hDEADBEEF);
    chk("lw_sel", {27'b0, bus.o_selected_reg}, 32'd9);
    chk("lw_m2r", {31'b0, bus.o_mem_to_reg}, 32'h1);
    op(1, 1, 1, 1, 0, 2'b00, 0, 32'h9, 32'h0, 5'd9, 5'd2);
    chk("lb_9", bus.o_mem_data, 32'hFFFFFFBE);
    op(1, 1, 1, 1, 0, 2'b00, 1, 32'h9, 32'h0, 5'd9, 5'd2);
    chk("lbu_9", bus.o_mem_data, 32'h000000BE);
    op(1, 1, 1, 1, 0, 2'b01, 0, 32'hA, 32'h0, 5'd9, 5'd2);
    chk("lh_a", bus.o_mem_data, 32'hFFFFDEAD);
    op(1, 1, 1, 1, 0, 2'b01, 1, 32'h8, 32'h0, 5'd9, 5'd2);
    chk("lhu_8", bus.o_mem_data, 32'h0000BEEF);

    // Partial stores touch only their lanes
    op(1, 0, 0, 0, 1, 2'b00, 0, 32'hB, 32'hAAAAAA12, 5'd0, 5'd2);
    chk("sb_b", bus.o_debug_data, 32'h12ADBEEF);
    op(1, 0, 0, 0, 1, 2'b01, 0, 32'h8, 32'h55553456, 5'd0, 5'd2);
    chk("sh_8", bus.o_debug_data, 32'h12AD3456);

    // Misaligned accesses
    op(1, 0, 0, 0, 1, 2'b10, 0, 32'h6, 32'h11111111, 5'd0, 5'd1);
    chk("sw6_debug1", bus.o_debug_data, 32'h0);
    chk("sw6_mis",    {31'b0, bus.o_misaligned}, 32'h1);
    op(1, 0, 0, 1, 0, 2'b01, 0, 32'h5, 32'h0, 5'd0, 5'd2);
    chk("lh5_data",   bus.o_mem_data, 32'h0);
    chk("lh5_mis",    {31'b0, bus.o_misaligned}, 32'h1);
    chk("lh5_debug2", bus.o_debug_data, 32'h12AD3456);
    op(1, 0, 0, 1, 0, 2'b11, 0, 32'h8, 32'h0, 5'd0, 5'd2);
    chk("rsvd_data", bus.o_mem_data, 32'h0);
    chk("rsvd_mis",  {31'b0, bus.o_misaligned}, 32'h1);
    op(1, 0, 0, 0, 0, 2'b11, 0, 32'h8, 32'h0, 5'd0, 5'd2);
    chk("rsvd_idle_mis", {31'b0, bus.o_misaligned}, 32'h0);

    // Read and write together: load sees the old word
    op(1, 1, 1, 1, 1, 2'b10, 0, 32'h8, 32'hCAFEF00D, 5'd3, 5'd2);
    chk("rbw_data",  bus.o_mem_data, 32'h12AD3456);
    chk("rbw_debug", bus.o_debug_data, 32'hCAFEF00D);

    // Freeze with i_step=0
    op(0, 0, 0, 1, 1, 2'b10, 1, 32'h0, 32'hFFFFFFFF, 5'd31, 5'd0);
    chk("hold_debug0", bus.o_debug_data, 32'h0);
    chk("hold_data",   bus.o_mem_data, 32'h12AD3456);
    chk("hold_alu",    bus.o_alu_result, 32'h8);
    chk("hold_rw",     {31'b0, bus.o_reg_write}, 32'h1);
    chk("hold_m2r",    {31'b0, bus.o_mem_to_reg}, 32'h1);
    chk("hold_sel",    {27'b0, bus.o_selected_reg}, 32'd3);
    op(1, 0, 0, 1, 1, 2'b10, 1, 32'h0, 32'hFFFFFFFF, 5'd31, 5'd0);
    chk("step_debug0", bus.o_debug_data, 32'hFFFFFFFF);
    chk("step_data",   bus.o_mem_data, 32'h0);
    chk("step_alu",    bus.o_alu_result, 32'h0);
    chk("step_sel",    {27'b0, bus.o_selected_reg}, 32'd31);

    op(1, 0, 0, 0, 1, 2'b00, 0, 32'hD, 32'h00000077, 5'd0, 5'd3);
    chk("sb_d", bus.o_debug_data, 32'h00007700);

    // Asynchronous reset between edges with a store pending
    @(negedge clk);
    drive(1, 1, 1, 1, 1, 2'b10, 0, 32'h10, 32'h5A5A5A5A, 5'd7, 5'd2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_debug2", bus.o_debug_data, 32'h0);
    chk("arst_data",   bus.o_mem_data, 32'h0);
    chk("arst_alu",    bus.o_alu_result, 32'h0);
    chk("arst_rw",     {31'b0, bus.o_reg_write}, 32'h0);
    chk("arst_m2r",    {31'b0, bus.o_mem_to_reg}, 32'h0);
    chk("arst_sel",    {27'b0, bus.o_selected_reg}, 32'h0);
    @(posedge clk);
    #1;
    for (int i = 0; i < 32; i++) begin
      bus.i_debug_addr = 5'(i);
      #1;
      chk($sformatf("arst_word%0d", i), bus.o_debug_data, 32'h0);
    end

    // Release with i_step=0: pending store must not land
    @(negedge clk);
    bus.i_step       = 1'b0;
    bus.i_debug_addr = 5'd4;
    rst_n            = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_hold_debug4", bus.o_debug_data, 32'h0);
    chk("post_rst_hold_alu",    bus.o_alu_result, 32'h0);

    // 0x88 wraps onto word 2
    op(1, 0, 0, 0, 1, 2'b10, 0, 32'h88, 32'h0BADCAFE, 5'd0, 5'd2);
    chk("wrap_debug2", bus.o_debug_data, 32'h0BADCAFE);
    op(1, 0, 0, 1, 0, 2'b10, 0, 32'h8, 32'h0, 5'd0, 5'd2);
    chk("wrap_lw8", bus.o_mem_data, 32'h0BADCAFE);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
